// File: rtl/scrypt_job_sequencer_if.sv
// Handshake bundle between the I2C controller, header RAM, scrypt core and the job sequencer.
// The sequencer takes the slave modport; the surrounding logic (or a bench) takes master.
interface scrypt_job_sequencer_if #(
  parameter int unsigned HDR_BYTES = 80,
  parameter int unsigned AW        = $clog2(HDR_BYTES)
);
  logic [7:0]    rx_byte;
  logic          notify;
  logic          stop_found;
  logic          load_data;
  logic          inc_data;
  logic [7:0]    tx_byte;
  logic          valid_nonce;
  logic          hdr_we;
  logic [AW-1:0] hdr_addr;
  logic [7:0]    hdr_wdata;
  logic          core_start;
  logic          core_abort;
  logic          core_found;
  logic [31:0]   core_nonce;
  logic          core_done;
  logic          busy;
  logic          exhausted;
  logic          timeout;

  modport slave (
    input  rx_byte, notify, stop_found, load_data, inc_data, core_found, core_nonce, core_done,
    output tx_byte, valid_nonce, hdr_we, hdr_addr, hdr_wdata, core_start, core_abort, busy,
           exhausted, timeout
  );

  modport master (
    output rx_byte, notify, stop_found, load_data, inc_data, core_found, core_nonce, core_done,
    input  tx_byte, valid_nonce, hdr_we, hdr_addr, hdr_wdata, core_start, core_abort, busy,
           exhausted, timeout
  );
endinterface

// File: rtl/scrypt_job_sequencer.sv
// Sequences one scrypt mining job: header collection, core launch, nonce readback over I2C.
// Optional hashing watchdog enabled by defining SCRYPT_WATCHDOG_EN.
module scrypt_job_sequencer #(
  parameter int unsigned HDR_BYTES   = 80,
  parameter int unsigned NONCE_BYTES = 4,
  parameter int unsigned TIMEOUT_CYC = 2**28
) (
  input logic                  clk,
  input logic                  n_rst,
  scrypt_job_sequencer_if.slave bus
);
  localparam int unsigned AW = $clog2(HDR_BYTES);
  localparam int unsigned IW = (NONCE_BYTES > 1) ? $clog2(NONCE_BYTES) : 1;

  typedef enum logic [2:0] {StCollect, StArmed, StStart, StHash, StResult} state_e;

  state_e        r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [IW-1:0] r_tx_idx;
  logic [31:0]   r_nonce;
  logic          r_core_start;
  logic          r_exhausted;
  logic          r_timeout;
  logic          w_core_abort;
  logic          w_wd_hit;
  logic          w_unused;

`ifdef SCRYPT_WATCHDOG_EN
  logic [31:0] r_wd_cnt;
  assign w_wd_hit = (r_wd_cnt == 32'(TIMEOUT_CYC - 1));
  assign w_unused = bus.load_data;
`else
  assign w_wd_hit = 1'b0;
  assign w_unused = ^{bus.load_data, 32'(TIMEOUT_CYC)};
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= StCollect;
      r_wr_ptr     <= '0;
      r_tx_idx     <= '0;
      r_nonce      <= '0;
      r_core_start <= 1'b0;
      r_exhausted  <= 1'b0;
      r_timeout    <= 1'b0;
`ifdef SCRYPT_WATCHDOG_EN
      r_wd_cnt     <= '0;
`endif
    end else begin
      r_core_start <= 1'b0;
      if (bus.notify) begin
        r_exhausted <= 1'b0;
        r_timeout   <= 1'b0;
      end
      unique case (r_state)
        StCollect: begin
          if (bus.notify) begin
            if (r_wr_ptr == AW'(HDR_BYTES - 1)) begin
              r_wr_ptr <= '0;
              if (bus.stop_found) begin
                r_state      <= StStart;
                r_core_start <= 1'b1;
              end else begin
                r_state <= StArmed;
              end
            end else if (bus.stop_found) begin
              r_wr_ptr <= '0;
            end else begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
            end
          end else if (bus.stop_found) begin
            r_wr_ptr <= '0;  // partial header is discarded
          end
        end
        StArmed: begin
          if (bus.notify) begin
            r_wr_ptr <= AW'(1);
            r_state  <= StCollect;
          end else if (bus.stop_found) begin
            r_state      <= StStart;
            r_core_start <= 1'b1;
          end
        end
        StStart: begin
          r_state <= StHash;
`ifdef SCRYPT_WATCHDOG_EN
          r_wd_cnt <= '0;
`endif
        end
        StHash: begin
          if (bus.notify) begin
            r_wr_ptr <= AW'(1);
            r_state  <= StCollect;
          end else if (bus.core_found) begin
            r_nonce  <= bus.core_nonce;
            r_tx_idx <= '0;
            r_state  <= StResult;
          end else if (bus.core_done) begin
            r_exhausted <= 1'b1;
            r_state     <= StCollect;
          end else if (w_wd_hit) begin
            r_timeout <= 1'b1;
            r_state   <= StCollect;
          end
`ifdef SCRYPT_WATCHDOG_EN
          r_wd_cnt <= r_wd_cnt + 1'b1;
`endif
        end
        StResult: begin
          if (bus.notify) begin
            r_wr_ptr <= AW'(1);
            r_tx_idx <= '0;
            r_state  <= StCollect;
          end else if (bus.stop_found) begin
            r_tx_idx <= '0;  // keep the result so a re-read restarts at byte 0
          end else if (bus.inc_data) begin
            if (r_tx_idx == IW'(NONCE_BYTES - 1)) begin
              r_tx_idx <= '0;
              r_state  <= StCollect;
            end else begin
              r_tx_idx <= r_tx_idx + 1'b1;
            end
          end
        end
        default: r_state <= StCollect;
      endcase
    end
  end

  // Abort must coincide with the cycle that kills the hash, so it is decoded from current state.
  always_comb begin
    w_core_abort = 1'b0;
    if (r_state == StHash) begin
      if (bus.notify) begin
        w_core_abort = 1'b1;
      end else if (!bus.core_found && !bus.core_done && w_wd_hit) begin
        w_core_abort = 1'b1;
      end
    end
  end

  assign bus.hdr_we      = bus.notify;
  assign bus.hdr_addr    = r_wr_ptr;
  assign bus.hdr_wdata   = bus.rx_byte;
  assign bus.tx_byte     = r_nonce[{r_tx_idx, 3'b000} +: 8];
  assign bus.valid_nonce = (r_state == StResult);
  assign bus.busy        = (r_state == StStart) || (r_state == StHash);
  assign bus.core_start  = r_core_start;
  assign bus.core_abort  = w_core_abort;
  assign bus.exhausted   = r_exhausted;
  assign bus.timeout     = r_timeout;
endmodule
